// File: rtl/hdmi_sched_pkg.sv
// Shared definitions for the HDMI data-island scheduler.
//   sched_state_e : scheduler FSM states
//   SRC_*         : bit positions of the request/grant vectors
//   *_LEN         : island phase lengths in pixel clocks
package hdmi_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        PREAMBLE,
        LGUARD,
        PACKET,
        TGUARD,
        WAITLINE
    } sched_state_e;

    localparam int unsigned SRC_ACR = 0;
    localparam int unsigned SRC_AUD = 1;
    localparam int unsigned SRC_AVI = 2;
    localparam int unsigned SRC_AIF = 3;

    localparam int unsigned PREAMBLE_LEN = 8;
    localparam int unsigned GUARD_LEN    = 2;
    localparam int unsigned PKT_LEN      = 32;

endpackage

// File: rtl/hdmi_sched_arbiter.sv
// Packet-source arbiter: fixed priority ACR > audio sample > infoframes,
// with the two infoframe sources (AVI, audio) sharing the lowest level
// round-robin.
//   clk, reset : pixel clock, synchronous active-high reset
//   i_elig     : eligible requests, indexed by SRC_*
//   i_take     : the current grant is being issued this cycle
//   o_gnt      : one-hot combinational grant (zero when nothing eligible)
//   o_idx      : index of the granted source
module hdmi_sched_arbiter
    import hdmi_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_elig,
    input  logic       i_take,
    output logic [3:0] o_gnt,
    output logic [1:0] o_idx
);

    // rr_q = 0: AVI wins a tie against the audio infoframe; 1: audio infoframe wins.
    logic rr_q, rr_d;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        if (i_elig[SRC_ACR]) begin
            o_gnt[SRC_ACR] = 1'b1;
            o_idx          = 2'(SRC_ACR);
        end else if (i_elig[SRC_AUD]) begin
            o_gnt[SRC_AUD] = 1'b1;
            o_idx          = 2'(SRC_AUD);
        end else if (i_elig[SRC_AVI] && (!rr_q || !i_elig[SRC_AIF])) begin
            o_gnt[SRC_AVI] = 1'b1;
            o_idx          = 2'(SRC_AVI);
        end else if (i_elig[SRC_AIF]) begin
            o_gnt[SRC_AIF] = 1'b1;
            o_idx          = 2'(SRC_AIF);
        end
    end

    // Pointer moves only when an infoframe is actually granted.
    always_comb begin
        rr_d = rr_q;
        if (i_take && o_gnt[SRC_AVI]) begin
            rr_d = 1'b1;
        end else if (i_take && o_gnt[SRC_AIF]) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island scheduler. On each blanking interval it waits START_DLY
// pixel clocks, then (if any packet is requested) emits preamble, leading
// guard band, up to MAX_PKTS back-to-back 32-cycle packets and a trailing
// guard band. One island per blanking interval; a blank falling edge inside
// an island aborts it and sets the sticky error flag.
//   i_pixclk, i_reset   : pixel clock, synchronous active-high reset
//   i_hSync, i_vSync    : syncs (i_vSync only used with the option below)
//   i_blank             : high during blanking
//   i_req[3:0]          : level requests (ACR, audio, AVI IF, audio IF)
//   o_grant[3:0]        : one-hot pulse at the start of the granted packet
//   o_sel, o_pkt_start, o_pkt_cnt : packet in flight, cycle-0 pulse, cycle 0..31
//   o_preamble, o_guard, o_data   : island phase indicators
//   o_err               : sticky abort flag
// Option macro HDMI_SCHED_VBLANK_INFO_EN: infoframes are only eligible on
// lines where i_vSync was seen high since the last blank falling edge.
module hdmi_island_scheduler
    import hdmi_sched_pkg::*;
#(
    parameter int unsigned START_DLY = 4,
    parameter int unsigned MAX_PKTS  = 2
) (
    input  logic       i_pixclk,
    input  logic       i_reset,
    input  logic       i_hSync,
    input  logic       i_vSync,
    input  logic       i_blank,
    input  logic [3:0] i_req,
    output logic [3:0] o_grant,
    output logic [1:0] o_sel,
    output logic       o_pkt_start,
    output logic [4:0] o_pkt_cnt,
    output logic       o_preamble,
    output logic       o_guard,
    output logic       o_data,
    output logic       o_err
);

    localparam int unsigned CNT_SPAN = (START_DLY > PKT_LEN) ? START_DLY : PKT_LEN;
    localparam int unsigned CNT_W    = $clog2(CNT_SPAN);
    localparam int unsigned DLY_LAST = (START_DLY > 0) ? START_DLY - 1 : 0;

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       pkts_q, pkts_d;
    logic [3:0]       served_q, served_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic             err_q, err_d;
    logic             blank_prev_q, blank_prev_d;

    logic       blank_rise, blank_fall;
    logic [3:0] elig_mask, elig, arb_gnt;
    logic [1:0] arb_idx;
    logic       arb_take;
    logic       unused_sync;

    assign blank_rise   = i_blank & ~blank_prev_q;
    assign blank_fall   = ~i_blank & blank_prev_q;
    assign blank_prev_d = i_blank;

`ifdef HDMI_SCHED_VBLANK_INFO_EN
    logic vs_seen_q, vs_seen_d;

    // Includes the current sample so a vSync coinciding with the decision
    // cycle still qualifies.
    always_comb begin
        vs_seen_d = (blank_fall ? 1'b0 : vs_seen_q) | i_vSync;
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            vs_seen_q <= 1'b0;
        end else begin
            vs_seen_q <= vs_seen_d;
        end
    end

    assign elig_mask   = (vs_seen_q | i_vSync) ? 4'b1111 : 4'b0011;
    assign unused_sync = i_hSync;
`else
    assign elig_mask   = 4'b1111;
    assign unused_sync = i_hSync ^ i_vSync;
`endif

    // A source granted in this island is not granted again until the next
    // island; a request still held at its grant therefore counts as a new
    // request for the next island's slots.
    assign elig = i_req & ~served_q & elig_mask;

    hdmi_sched_arbiter u_arbiter (
        .clk    (i_pixclk),
        .reset  (i_reset),
        .i_elig (elig),
        .i_take (arb_take),
        .o_gnt  (arb_gnt),
        .o_idx  (arb_idx)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pkts_d   = pkts_q;
        served_d = served_q;
        grant_d  = '0;
        sel_d    = sel_q;
        err_d    = err_q;
        arb_take = 1'b0;

        if (blank_fall && (state_q == PREAMBLE || state_q == LGUARD ||
                           state_q == PACKET   || state_q == TGUARD)) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (blank_rise) begin
                        state_d  = DELAY;
                        cnt_d    = '0;
                        pkts_d   = '0;
                        served_d = '0;
                    end
                end
                DELAY: begin
                    if (blank_fall) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(DLY_LAST)) begin
                        cnt_d   = '0;
                        state_d = (|elig) ? PREAMBLE : WAITLINE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PREAMBLE: begin
                    if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = LGUARD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LGUARD: begin
                    if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                        cnt_d = '0;
                        // A request withdrawn before arbitration closes the
                        // island with the trailing guard instead of an empty packet.
                        if (|arb_gnt) begin
                            state_d  = PACKET;
                            arb_take = 1'b1;
                        end else begin
                            state_d = TGUARD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PACKET: begin
                    if (cnt_q == CNT_W'(PKT_LEN - 1)) begin
                        cnt_d = '0;
                        if ((pkts_q < 5'(MAX_PKTS)) && (|arb_gnt)) begin
                            arb_take = 1'b1;
                        end else begin
                            state_d = TGUARD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                TGUARD: begin
                    if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = WAITLINE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAITLINE: begin
                    if (blank_fall) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (arb_take) begin
            grant_d  = arb_gnt;
            sel_d    = arb_idx;
            served_d = served_q | arb_gnt;
            pkts_d   = (pkts_q < 5'(MAX_PKTS)) ? pkts_q + 5'd1 : pkts_q;
        end
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pkts_q       <= '0;
            served_q     <= '0;
            grant_q      <= '0;
            sel_q        <= '0;
            err_q        <= 1'b0;
            blank_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pkts_q       <= pkts_d;
            served_q     <= served_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            err_q        <= err_d;
            blank_prev_q <= blank_prev_d;
        end
    end

    always_comb begin
        o_grant     = grant_q;
        o_sel       = sel_q;
        o_err       = err_q;
        o_preamble  = (state_q == PREAMBLE);
        o_guard     = (state_q == LGUARD) || (state_q == TGUARD);
        o_data      = (state_q == PACKET);
        o_pkt_start = (state_q == PACKET) && (cnt_q == '0);
        o_pkt_cnt   = (state_q == PACKET) ? 5'(cnt_q) : 5'd0;
    end

endmodule
